// File: rtl/i2s_line_in_receiver.sv
// I2S master receiver: generates mclk/sclk/lrclk from clk, deserializes ADC data
// into left/right word pairs and offers them on a valid/ready holding register.
module i2s_line_in_receiver #(
    parameter int MCLK_HALF = 4,
    parameter int SCLK_HALF = 16,
    parameter int SLOT_BITS = 32,
    parameter int SAMPLE_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_i,
    input  logic                sdin_i,
    input  logic                sample_ready_i,
    input  logic                clr_overrun_i,
    output logic                mclk_o,
    output logic                sclk_o,
    output logic                lrclk_o,
    output logic [SAMPLE_W-1:0] left_sample_o,
    output logic [SAMPLE_W-1:0] right_sample_o,
    output logic                sample_valid_o,
    output logic                overrun_o
);

    localparam int MCW = $clog2(MCLK_HALF + 1);
    localparam int SCW = $clog2(2 * SCLK_HALF + 1);
    localparam int BCW = $clog2(2 * SLOT_BITS + 1);

    localparam logic [MCW-1:0] MCNT_LAST = MCW'(MCLK_HALF - 1);
    localparam logic [SCW-1:0] SCNT_LAST = SCW'(2 * SCLK_HALF - 1);
    localparam logic [SCW-1:0] SCNT_RISE = SCW'(SCLK_HALF);
    localparam logic [BCW-1:0] BCNT_LAST = BCW'(2 * SLOT_BITS - 1);
    localparam logic [BCW-1:0] SLOT_LEN  = BCW'(SLOT_BITS);
    localparam logic [BCW-1:0] WORD_LAST = BCW'(SAMPLE_W);
    localparam logic [BCW-1:0] WORD_FIRST = BCW'(1);

    logic [MCW-1:0]      mcnt_q, mcnt_d;
    logic [SCW-1:0]      scnt_q, scnt_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                mclk_q, mclk_d;
    logic                sclk_q, sclk_d;
    logic                lrclk_q, lrclk_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] left_hold_q, left_hold_d;
    logic                done_q, done_d;
    logic [SAMPLE_W-1:0] left_q, left_d;
    logic [SAMPLE_W-1:0] right_q, right_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;

    logic                right_slot;
    logic [BCW-1:0]      slot_k;
    logic                sample_tick;
    logic                in_word;
    logic                load;
    logic                drop;

    always_comb begin
        right_slot  = (bit_cnt_q >= SLOT_LEN);
        slot_k      = right_slot ? (bit_cnt_q - SLOT_LEN) : bit_cnt_q;
        sample_tick = enable_i && (scnt_q == SCNT_RISE);
        in_word     = (slot_k >= WORD_FIRST) && (slot_k <= WORD_LAST);
    end

    // Clock generation and serial capture
    always_comb begin
        mcnt_d      = '0;
        scnt_d      = '0;
        bit_cnt_d   = '0;
        mclk_d      = 1'b0;
        sclk_d      = 1'b0;
        lrclk_d     = 1'b0;
        shift_d     = '0;
        left_hold_d = '0;
        done_d      = 1'b0;
        if (enable_i) begin
            mcnt_d      = (mcnt_q == MCNT_LAST) ? '0 : mcnt_q + 1'b1;
            mclk_d      = (mcnt_q == MCNT_LAST) ? ~mclk_q : mclk_q;
            scnt_d      = (scnt_q == SCNT_LAST) ? '0 : scnt_q + 1'b1;
            bit_cnt_d   = bit_cnt_q;
            if (scnt_q == SCNT_LAST) begin
                bit_cnt_d = (bit_cnt_q == BCNT_LAST) ? '0 : bit_cnt_q + 1'b1;
            end
            // Output clocks are registered copies of the next counter state
            sclk_d      = (scnt_d >= SCNT_RISE);
            lrclk_d     = (bit_cnt_d >= SLOT_LEN);
            shift_d     = shift_q;
            left_hold_d = left_hold_q;
            if (sample_tick && in_word) begin
                shift_d = SAMPLE_W'({shift_q, sdin_i});
                if (slot_k == WORD_LAST) begin
                    if (right_slot) begin
                        done_d = 1'b1;
                    end else begin
                        left_hold_d = shift_d;
                    end
                end
            end
        end
    end

    // Holding register and handshake; a frame completes one cycle after its last bit
    always_comb begin
        load    = done_q && (!valid_q || sample_ready_i);
        drop    = done_q && !load;
        left_d  = left_q;
        right_d = right_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (load) begin
            left_d  = left_hold_q;
            right_d = shift_q;
            valid_d = 1'b1;
        end else if (valid_q && sample_ready_i) begin
            valid_d = 1'b0;
        end
        if (clr_overrun_i) begin
            ovr_d = 1'b0;
        end
        if (drop) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcnt_q      <= '0;
            scnt_q      <= '0;
            bit_cnt_q   <= '0;
            mclk_q      <= 1'b0;
            sclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            shift_q     <= '0;
            left_hold_q <= '0;
            done_q      <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            mcnt_q      <= mcnt_d;
            scnt_q      <= scnt_d;
            bit_cnt_q   <= bit_cnt_d;
            mclk_q      <= mclk_d;
            sclk_q      <= sclk_d;
            lrclk_q     <= lrclk_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            done_q      <= done_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign mclk_o         = mclk_q;
    assign sclk_o         = sclk_q;
    assign lrclk_o        = lrclk_q;
    assign left_sample_o  = left_q;
    assign right_sample_o = right_q;
    assign sample_valid_o = valid_q;
    assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_i2s_line_in_receiver.sv
// Bench for i2s_line_in_receiver: ADC data and expected outputs derived from
// cycle position within an enabled run (frame/slot/bit arithmetic).
module tb_i2s_line_in_receiver;

    localparam int MH    = 4;
    localparam int SH    = 16;
    localparam int SB    = 32;
    localparam int W     = 16;
    localparam int FRAME = 2 * SB * 2 * SH;
    localparam int FIRST = 2 * SH * (SB + W) + SH + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_i;
    logic          sdin_i;
    logic          sample_ready_i;
    logic          clr_overrun_i;
    logic          mclk_o;
    logic          sclk_o;
    logic          lrclk_o;
    logic [W-1:0]  left_sample_o;
    logic [W-1:0]  right_sample_o;
    logic          sample_valid_o;
    logic          overrun_o;

    i2s_line_in_receiver #(
        .MCLK_HALF(MH), .SCLK_HALF(SH), .SLOT_BITS(SB), .SAMPLE_W(W)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .sdin_i(sdin_i),
        .sample_ready_i(sample_ready_i), .clr_overrun_i(clr_overrun_i),
        .mclk_o(mclk_o), .sclk_o(sclk_o), .lrclk_o(lrclk_o),
        .left_sample_o(left_sample_o), .right_sample_o(right_sample_o),
        .sample_valid_o(sample_valid_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: run_n is the index of the last edge within the current enabled run
    int           run_n = -1;
    logic [W-1:0] lw [16];
    logic [W-1:0] rw [16];
    logic [63:0]  fill = '1;
    logic         ev = 1'b0;
    logic [W-1:0] el = '0;
    logic [W-1:0] er = '0;
    logic         eo = 1'b0;
    logic         pend = 1'b0;
    logic [W-1:0] pl = '0;
    logic [W-1:0] pr = '0;

    function automatic logic adc_bit(input int m);
        int f;
        int b;
        int k;
        logic [W-1:0] wd;
        f  = (m / FRAME) % 16;
        b  = (m / (2 * SH)) % (2 * SB);
        k  = b % SB;
        wd = (b >= SB) ? rw[f] : lw[f];
        if (k >= 1 && k <= W) return wd[W-k];
        return fill[b];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (run_n=%0d)", tag, obs, exp, run_n);
        end
    endtask

    task automatic step();
        logic drop;
        logic emclk, esclk, elr;
        int   f;
        sdin_i = adc_bit(run_n + 1);
        @(posedge clk);
        drop = 1'b0;
        if (rst) begin
            run_n = -1; ev = 1'b0; el = '0; er = '0; eo = 1'b0; pend = 1'b0;
        end else begin
            if (pend) begin
                if (!ev || sample_ready_i) begin
                    ev = 1'b1; el = pl; er = pr;
                end else begin
                    drop = 1'b1;
                end
            end else if (ev && sample_ready_i) begin
                ev = 1'b0;
            end
            if (clr_overrun_i) eo = 1'b0;
            if (drop) eo = 1'b1;
            run_n = enable_i ? run_n + 1 : -1;
            pend  = (run_n >= 0) && ((run_n % FRAME) == FIRST - 1);
            if (pend) begin
                f  = (run_n / FRAME) % 16;
                pl = lw[f];
                pr = rw[f];
            end
        end
        #1;
        emclk = 1'b0; esclk = 1'b0; elr = 1'b0;
        if (run_n >= 0) begin
            emclk = (((run_n + 1) / MH) % 2) == 1;
            esclk = ((run_n + 1) % (2 * SH)) >= SH;
            elr   = (((run_n + 1) / (2 * SH)) % (2 * SB)) >= SB;
        end
        check("mclk",    W'(mclk_o),         W'(emclk));
        check("sclk",    W'(sclk_o),         W'(esclk));
        check("lrclk",   W'(lrclk_o),        W'(elr));
        check("valid",   W'(sample_valid_o), W'(ev));
        check("overrun", W'(overrun_o),      W'(eo));
        check("left",    left_sample_o,      el);
        check("right",   right_sample_o,     er);
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (run_n != target && guard < 20000) begin
            step();
            guard++;
        end
        total++;
        assert (run_n == target) else begin
            bad++;
            $error("FAIL run_to observed=%0d expected=%0d", run_n, target);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable_i = 1'b1; sdin_i = 1'b0;
        sample_ready_i = 1'b0; clr_overrun_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            lw[i] = W'($urandom); rw[i] = W'($urandom);
        end

        // Reset with enable high
        steps(3);
        check("rst_valid", W'(sample_valid_o), '0);
        check("rst_left",  left_sample_o, '0);
        check("rst_sclk",  W'(sclk_o), '0);

        // Basic capture, ignored bits all ones
        for (int i = 0; i < 4; i++) begin lw[i] = 16'hA5C3; rw[i] = 16'h1234; end
        fill = '1;
        sample_ready_i = 1'b1;
        rst = 1'b0;
        run_to(FIRST - 1);
        check("basic_pre_valid", W'(sample_valid_o), '0);
        step();
        check("basic_valid", W'(sample_valid_o), 16'h1);
        check("basic_left",  left_sample_o, 16'hA5C3);
        check("basic_right", right_sample_o, 16'h1234);
        step();
        check("basic_valid_drop", W'(sample_valid_o), '0);
        run_to(2 * FRAME + FIRST + 4);

        // Backpressure across two extra frames
        lw[0] = 16'h0001; rw[0] = 16'h0002;
        lw[1] = 16'h7FFF; rw[1] = 16'h8000;
        lw[2] = 16'h5555; rw[2] = 16'hAAAA;
        sample_ready_i = 1'b0;
        do_reset();
        run_to(2 * FRAME + FIRST + 5);
        check("bp_left",  left_sample_o, 16'h0001);
        check("bp_right", right_sample_o, 16'h0002);
        check("bp_ovr",   W'(overrun_o), 16'h1);
        clr_overrun_i = 1'b1;
        step();
        clr_overrun_i = 1'b0;
        check("bp_ovr_clr", W'(overrun_o), '0);
        sample_ready_i = 1'b1;
        steps(2);
        check("bp_valid_drop", W'(sample_valid_o), '0);
        sample_ready_i = 1'b0;

        // Accept and load on the same edge
        lw[0] = 16'h1357; rw[0] = 16'h2468;
        lw[1] = 16'hBEEF; rw[1] = 16'hCAFE;
        do_reset();
        run_to(FRAME + FIRST - 1);
        sample_ready_i = 1'b1;
        step();
        sample_ready_i = 1'b0;
        check("sim_valid", W'(sample_valid_o), 16'h1);
        check("sim_left",  left_sample_o, 16'hBEEF);
        check("sim_right", right_sample_o, 16'hCAFE);
        check("sim_ovr",   W'(overrun_o), '0);
        steps(20);

        // Enable drop in the middle of the right slot
        sample_ready_i = 1'b1;
        fill = {$urandom, $urandom};
        do_reset();
        run_to(FRAME + 40 * 2 * SH);
        enable_i = 1'b0;
        steps(100);
        check("en_sclk_low", W'(sclk_o), '0);
        lw[0] = 16'h1111; rw[0] = 16'h2222;
        enable_i = 1'b1;
        run_to(FIRST - 1);
        check("en_no_partial", W'(sample_valid_o), '0);
        step();
        check("en_left",  left_sample_o, 16'h1111);
        check("en_right", right_sample_o, 16'h2222);

        // Reset mid-frame while a frame is held
        sample_ready_i = 1'b0;
        lw[1] = 16'hDEAD; rw[1] = 16'hF00D;
        do_reset();
        run_to(FRAME + 20 * 2 * SH);
        check("rm_valid_held", W'(sample_valid_o), 16'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rm_valid", W'(sample_valid_o), '0);
        check("rm_left",  left_sample_o, '0);
        check("rm_lrclk", W'(lrclk_o), '0);
        lw[0] = 16'h0F0F; rw[0] = 16'h7070;
        sample_ready_i = 1'b1;
        run_to(FIRST);
        check("rm_new_left", left_sample_o, 16'h0F0F);

        // Randomized run: rare then frequent ready, sporadic overrun clears
        for (int i = 0; i < 16; i++) begin
            lw[i] = W'($urandom); rw[i] = W'($urandom);
        end
        fill = {$urandom, $urandom};
        do_reset();
        for (int i = 0; i < 8 * FRAME; i++) begin
            sample_ready_i = (i < 4 * FRAME) ? ($urandom_range(0, 2999) == 0)
                                             : ($urandom_range(0, 1) == 0);
            clr_overrun_i  = ($urandom_range(0, 999) == 0);
            step();
        end
        sample_ready_i = 1'b0;
        clr_overrun_i  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
